// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings, FSM states and cfg field offsets for the UART FIFO core
package uart_pkg;
  localparam logic [1:0] NB_8 = 2'b00, NB_7 = 2'b01, NB_6 = 2'b10, NB_5 = 2'b11;
  localparam logic [1:0] PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP1, RX_STOP2} rx_state_t;
  function automatic int cfg_nb_lsb(input int baudbits);
    return baudbits;
  endfunction
  function automatic int cfg_stop_bit(input int baudbits);
    return baudbits + 2;
  endfunction
  function automatic int cfg_par_lsb(input int baudbits);
    return baudbits + 3;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: show-ahead synchronous FIFO; a push on full is accepted when a pop happens the same cycle
module uart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wp, rp;
  logic do_pop, do_push;
  assign empty = wp == rp;
  assign full = wp == {~rp[DEPTH_LOG2], rp[DEPTH_LOG2-1:0]};
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rp[DEPTH_LOG2-1:0]];
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[DEPTH_LOG2-1:0]] <= din;
endmodule

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with TX/RX FIFOs and runtime data length, stop and parity config
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int BAUDBITS     = 9,
  parameter int TXDEPTH_LOG2 = 4,
  parameter int RXDEPTH_LOG2 = 4,
  parameter int RST_DIV      = 0
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [7:0]  wdata,
  input  logic        wrtx,
  input  logic [15:0] cfg,
  input  logic        wrconfig,
  output logic [7:0]  rdata,
  input  logic        rd,
  output logic        dv,
  output logic        fe,
  output logic        pe,
  output logic        ove,
  output logic        thre,
  output logic        tend,
  output logic        txd,
  input  logic        rxd
);
  localparam int NBL = cfg_nb_lsb(BAUDBITS);
  localparam int STB = cfg_stop_bit(BAUDBITS);
  localparam int PRL = cfg_par_lsb(BAUDBITS);
  logic [BAUDBITS-1:0] div_q;
  logic [1:0] nb_q, par_q;
  logic stop_q, unused_cfg;
  assign unused_cfg = ^(cfg >> (BAUDBITS + 5));
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      div_q <= BAUDBITS'(RST_DIV);
      nb_q <= NB_8;
      stop_q <= 1'b0;
      par_q <= PAR_NONE;
    end else if (wrconfig) begin
      div_q <= cfg[BAUDBITS-1:0];
      nb_q <= cfg[NBL +: 2];
      stop_q <= cfg[STB];
      par_q <= cfg[PRL +: 2];
    end
  logic [7:0] tx_dout;
  logic tx_full, tx_empty, tx_pop;
  uart_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(TXDEPTH_LOG2)) u_txf (
    .clk(clk), .resetb(resetb), .push(wrtx), .pop(tx_pop), .din(wdata),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );
  tx_state_t tx_st, tx_nx;
  logic [BAUDBITS-1:0] tx_div, tx_cnt;
  logic [1:0] tx_nb, tx_pm;
  logic [2:0] tx_bit, tx_last;
  logic [7:0] tx_sh;
  logic tx_stop, tx_par, tx_tick, tx_done, tx_pen;
  assign tx_tick = tx_cnt == '0;
  assign tx_last = 3'd7 - {1'b0, tx_nb};
  assign tx_pen = tx_pm == PAR_EVEN || tx_pm == PAR_ODD;
  assign tx_done = tx_tick && (tx_st == TX_STOP2 || (tx_st == TX_STOP1 && !tx_stop));
  // the next character is fetched in the last stop clock so frames run back to back
  assign tx_pop = (tx_st == TX_IDLE || tx_done) && !tx_empty;
  always_comb begin
    tx_nx = tx_st;
    case (tx_st)
      TX_IDLE:   tx_nx = TX_IDLE;
      TX_START:  tx_nx = tx_tick ? TX_DATA : TX_START;
      TX_DATA:   tx_nx = (tx_tick && tx_bit == tx_last) ? (tx_pen ? TX_PARITY : TX_STOP1) : TX_DATA;
      TX_PARITY: tx_nx = tx_tick ? TX_STOP1 : TX_PARITY;
      TX_STOP1:  tx_nx = tx_tick ? (tx_stop ? TX_STOP2 : TX_IDLE) : TX_STOP1;
      default:   tx_nx = tx_tick ? TX_IDLE : TX_STOP2;
    endcase
    if (tx_pop) tx_nx = TX_START;
  end
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      tx_st <= TX_IDLE;
      tx_div <= '0;
      tx_cnt <= '0;
      tx_nb <= NB_8;
      tx_pm <= PAR_NONE;
      tx_stop <= 1'b0;
      tx_bit <= '0;
      tx_sh <= '0;
      tx_par <= 1'b0;
    end else begin
      tx_st <= tx_nx;
      if (tx_pop) begin
        tx_div <= div_q;
        tx_cnt <= div_q;
        tx_nb <= nb_q;
        tx_pm <= par_q;
        tx_stop <= stop_q;
        tx_bit <= '0;
        tx_sh <= tx_dout;
        tx_par <= par_q == PAR_ODD;
      end else if (tx_st != TX_IDLE) begin
        tx_cnt <= tx_tick ? tx_div : tx_cnt - 1'b1;
        if (tx_tick && tx_st == TX_DATA) begin
          tx_sh <= tx_sh >> 1;
          tx_par <= tx_par ^ tx_sh[0];
          tx_bit <= tx_bit + 1'b1;
        end
      end
    end
  assign txd = tx_st == TX_START ? 1'b0 : tx_st == TX_DATA ? tx_sh[0] : tx_st == TX_PARITY ? tx_par : 1'b1;
  assign thre = !tx_full;
  assign tend = tx_st == TX_IDLE && tx_empty;
  logic rx_s1, rx_s2, rx_s3, rx_fall;
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) {rx_s1, rx_s2, rx_s3} <= 3'b111;
    else {rx_s1, rx_s2, rx_s3} <= {rxd, rx_s1, rx_s2};
  // rx_s3 is the sampled line; rx_s2 looks one clock ahead so divider=0 still lands inside the start bit
  assign rx_fall = rx_s3 && !rx_s2;
  rx_state_t rx_st, rx_nx;
  logic [BAUDBITS-1:0] rx_div, rx_cnt;
  logic [1:0] rx_nb, rx_pm;
  logic [2:0] rx_bit, rx_last;
  logic [7:0] rx_sh;
  logic [9:0] rx_dout;
  logic rx_stop, rx_par, rx_pe, rx_fe, rx_tick, rx_done, rx_go, rx_pen, rx_full, rx_empty;
  assign rx_tick = rx_cnt == '0;
  assign rx_last = 3'd7 - {1'b0, rx_nb};
  assign rx_pen = rx_pm == PAR_EVEN || rx_pm == PAR_ODD;
  assign rx_done = rx_tick && (rx_st == RX_STOP2 || (rx_st == RX_STOP1 && !rx_stop));
  assign rx_go = (rx_st == RX_IDLE || rx_done) && rx_fall;
  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      RX_IDLE:   rx_nx = RX_IDLE;
      RX_START:  rx_nx = rx_tick ? (rx_s3 ? RX_IDLE : RX_DATA) : RX_START;
      RX_DATA:   rx_nx = (rx_tick && rx_bit == rx_last) ? (rx_pen ? RX_PARITY : RX_STOP1) : RX_DATA;
      RX_PARITY: rx_nx = rx_tick ? RX_STOP1 : RX_PARITY;
      RX_STOP1:  rx_nx = rx_tick ? (rx_stop ? RX_STOP2 : RX_IDLE) : RX_STOP1;
      default:   rx_nx = rx_tick ? RX_IDLE : RX_STOP2;
    endcase
    if (rx_go) rx_nx = RX_START;
  end
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      rx_st <= RX_IDLE;
      rx_div <= '0;
      rx_cnt <= '0;
      rx_nb <= NB_8;
      rx_pm <= PAR_NONE;
      rx_stop <= 1'b0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_par <= 1'b0;
      rx_pe <= 1'b0;
      rx_fe <= 1'b0;
    end else begin
      rx_st <= rx_nx;
      if (rx_go) begin
        rx_div <= div_q;
        rx_cnt <= div_q >> 1;
        rx_nb <= nb_q;
        rx_pm <= par_q;
        rx_stop <= stop_q;
        rx_bit <= '0;
        rx_sh <= '0;
        rx_par <= par_q == PAR_ODD;
        rx_pe <= 1'b0;
        rx_fe <= 1'b0;
      end else if (rx_st != RX_IDLE) begin
        rx_cnt <= rx_tick ? rx_div : rx_cnt - 1'b1;
        if (rx_tick && rx_st == RX_DATA) begin
          rx_sh <= {rx_s3, rx_sh[7:1]};
          rx_par <= rx_par ^ rx_s3;
          rx_bit <= rx_bit + 1'b1;
        end
        if (rx_tick && rx_st == RX_PARITY) rx_pe <= rx_par ^ rx_s3;
        if (rx_tick && rx_st == RX_STOP1) rx_fe <= !rx_s3;
      end
    end
  uart_sync_fifo #(.WIDTH(10), .DEPTH_LOG2(RXDEPTH_LOG2)) u_rxf (
    .clk(clk), .resetb(resetb), .push(rx_done), .pop(rd),
    .din({rx_fe || !rx_s3, rx_pe, rx_sh >> rx_nb}),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) ove <= 1'b0;
    else ove <= (rx_done && rx_full && !rd) || (ove && !rd);
  assign rdata = rx_dout[7:0];
  assign pe = rx_dout[8];
  assign fe = rx_dout[9];
  assign dv = !rx_empty;
endmodule
